// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter sequencer with branch flush, stall and halt
//
// Owns the PC register and drives the next-PC select of the branch mux.
// Optional feature macro: BRANCH_COUNT_EN (taken-branch counter register).
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_stall, i_halt          hold PC / stop fetching
//   i_resume                 leave HALT
//   i_branch_valid/_taken    resolved branch from execute stage
//   i_branch_target          branch target address (low 2 bits dropped)
//   o_pc_out, o_pc_plus4     current PC and PC+4
//   o_pc_sel                 branch mux select (1 = target)
//   o_pc_next                value the PC loads at the next edge
//   o_fetch_valid, o_flush   fetch qualifier and IF/ID squash
//   o_branch_count           taken-branch counter (0 when feature disabled)
module pc_sequencer #(
    parameter int             W            = 32,
    parameter logic [W-1:0]   RESET_PC     = '0,
    parameter int             FLUSH_CYCLES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_stall,
    input  logic         i_halt,
    input  logic         i_resume,
    input  logic         i_branch_valid,
    input  logic         i_branch_taken,
    input  logic [W-1:0] i_branch_target,
    output logic [W-1:0] o_pc_out,
    output logic [W-1:0] o_pc_plus4,
    output logic         o_pc_sel,
    output logic [W-1:0] o_pc_next,
    output logic         o_fetch_valid,
    output logic         o_flush,
    output logic [31:0]  o_branch_count
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    // Redirect cycle itself counts as one bubble, so FLUSH lasts FLUSH_CYCLES
    // cycles when the counter starts at FLUSH_CYCLES-1 and exits at zero.
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t       r_state;
    logic [W-1:0] r_pc;
    logic [3:0]   r_cnt;

    logic         w_redirect;
    logic [W-1:0] w_target;
    logic [W-1:0] w_pc_plus4;
    logic [W-1:0] w_pc_next;
    logic         w_unused_tgt;

    assign w_redirect   = i_branch_valid & i_branch_taken & (r_state == S_RUN);
    assign w_target     = {i_branch_target[W-1:2], 2'b00};
    assign w_pc_plus4   = r_pc + W'(4);
    assign w_unused_tgt = ^i_branch_target[1:0];

    // Redirect outranks halt and stall; PC only advances in an unstalled RUN cycle.
    always_comb begin
        w_pc_next = r_pc;
        if (w_redirect) begin
            w_pc_next = w_target;
        end else if ((r_state == S_RUN) && !i_halt && !i_stall) begin
            w_pc_next = w_pc_plus4;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_cnt   <= 4'd0;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                S_RUN: begin
                    if (w_redirect) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= CNT_INIT;
                    end else if (i_halt) begin
                        r_state <= S_HALT;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HALT: begin
                    if (i_resume) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

`ifdef BRANCH_COUNT_EN
    logic [31:0] r_branch_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_branch_count <= 32'd0;
        end else if (w_redirect) begin
            r_branch_count <= r_branch_count + 32'd1;
        end
    end

    assign o_branch_count = r_branch_count;
`else
    assign o_branch_count = 32'd0;
`endif

    assign o_pc_out      = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_pc_sel      = w_redirect;
    assign o_pc_next     = w_pc_next;
    assign o_fetch_valid = (r_state == S_RUN) & ~i_stall & ~i_halt & ~w_redirect;
    assign o_flush       = (r_state == S_FLUSH) | w_redirect;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam int FLUSH_CYCLES = 2;
`ifdef BRANCH_COUNT_EN
    localparam bit BC_ON = 1'b1;
`else
    localparam bit BC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        bv = 1'b0;
    logic        bt = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic [31:0] pc_out, pc_plus4, pc_next, branch_count;
    logic        pc_sel, fetch_valid, flush;

    int vectors = 0;
    int miscompares = 0;

    pc_sequencer #(.W(32), .RESET_PC(32'h0), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_halt(halt), .i_resume(resume),
        .i_branch_valid(bv), .i_branch_taken(bt), .i_branch_target(tgt),
        .o_pc_out(pc_out), .o_pc_plus4(pc_plus4), .o_pc_sel(pc_sel), .o_pc_next(pc_next),
        .o_fetch_valid(fetch_valid), .o_flush(flush), .o_branch_count(branch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, got, exp);
        end
    endtask

    // Model: PC, number of flush bubbles still owed, halted flag, taken-branch tally.
    logic [31:0] m_pc;
    int          m_left;
    bit          m_halted;
    logic [31:0] m_bc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 32'h0; m_left <= 0; m_halted <= 1'b0; m_bc <= 32'h0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else if (m_halted) begin
            if (resume) m_halted <= 1'b0;
        end else if (bv && bt) begin
            m_pc   <= tgt & ~32'h3;
            m_left <= FLUSH_CYCLES;
            m_bc   <= m_bc + 32'd1;
        end else if (halt) begin
            m_halted <= 1'b1;
        end else if (!stall) begin
            m_pc <= m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit          run, redir;
            logic [31:0] nxt;
            run   = !m_halted && (m_left == 0);
            redir = bv && bt && run;
            if (redir)                    nxt = tgt & ~32'h3;
            else if (run && !halt && !stall) nxt = m_pc + 32'd4;
            else                          nxt = m_pc;
            chk("m_pc_out", pc_out, m_pc);
            chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("m_pc_sel", {31'd0, pc_sel}, {31'd0, redir});
            chk("m_pc_next", pc_next, nxt);
            chk("m_fetch_valid", {31'd0, fetch_valid}, {31'd0, run && !stall && !halt && !redir});
            chk("m_flush", {31'd0, flush}, {31'd0, (m_left > 0) || redir});
            chk("m_branch_count", branch_count, BC_ON ? m_bc : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    task automatic clear_in();
        stall = 0; halt = 0; resume = 0; bv = 0; bt = 0; tgt = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        rst = 1; clear_in();
        @(posedge clk); #2;
        rst = 0;
    endtask

    initial begin
        // Reset and free-run
        clear_in();
        @(posedge clk); @(posedge clk); #2;
        rst = 0;
        look();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_plus4", pc_plus4, 32'h4);
        chk("rst_sel", {31'd0, pc_sel}, 32'd0);
        chk("rst_fetch", {31'd0, fetch_valid}, 32'd1);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_bcount", branch_count, 32'd0);
        for (int i = 1; i < 4; i++) begin
            step(); look();
            chk("free_pc", pc_out, 32'(i * 4));
        end

        // Taken branch at 0x8 to 0x102, then wrong-path branch during FLUSH
        apply_reset();
        step(); step();
        bv = 1; bt = 1; tgt = 32'h102;
        look();
        chk("br_pc", pc_out, 32'h8);
        chk("br_sel", {31'd0, pc_sel}, 32'd1);
        chk("br_next", pc_next, 32'h100);
        chk("br_flush0", {31'd0, flush}, 32'd1);
        step(); tgt = 32'h200;
        look();
        chk("br_pc1", pc_out, 32'h100);
        chk("br_flush1", {31'd0, flush}, 32'd1);
        chk("br_sel1", {31'd0, pc_sel}, 32'd0);
        step();
        look();
        chk("br_flush2", {31'd0, flush}, 32'd1);
        chk("br_fetch2", {31'd0, fetch_valid}, 32'd0);
        step(); clear_in();
        look();
        chk("br_pc3", pc_out, 32'h100);
        chk("br_flush3", {31'd0, flush}, 32'd0);
        chk("br_fetch3", {31'd0, fetch_valid}, 32'd1);
        chk("br_bcount", branch_count, BC_ON ? 32'd1 : 32'd0);
        step(); look();
        chk("br_pc4", pc_out, 32'h104);

        // Stall 3 cycles at 0x10, then stall plus taken branch to 0x40
        apply_reset();
        for (int i = 0; i < 4; i++) step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("stall_pc", pc_out, 32'h10);
            chk("stall_fetch", {31'd0, fetch_valid}, 32'd0);
            step();
        end
        bv = 1; bt = 1; tgt = 32'h40;
        look();
        chk("stall_br_sel", {31'd0, pc_sel}, 32'd1);
        step(); clear_in();
        look();
        chk("stall_br_pc", pc_out, 32'h40);
        step(); step(); look();
        chk("stall_br_fetch", {31'd0, fetch_valid}, 32'd1);
        step(); look();
        chk("stall_br_pc2", pc_out, 32'h44);

        // Halt at 0x20, branch ignored while halted, resume after 5 cycles
        apply_reset();
        for (int i = 0; i < 8; i++) step();
        halt = 1;
        look();
        chk("halt_pc", pc_out, 32'h20);
        chk("halt_fetch", {31'd0, fetch_valid}, 32'd0);
        step(); halt = 0; bv = 1; bt = 1; tgt = 32'h300;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) resume = 1;
            look();
            chk("halted_pc", pc_out, 32'h20);
            chk("halted_sel", {31'd0, pc_sel}, 32'd0);
            step();
        end
        clear_in();
        look();
        chk("resume_pc", pc_out, 32'h20);
        chk("resume_fetch", {31'd0, fetch_valid}, 32'd1);
        step(); look();
        chk("resume_pc2", pc_out, 32'h24);

        // Wrap-around from 0xFFFF_FFFC
        apply_reset();
        bv = 1; bt = 1; tgt = 32'hFFFF_FFFE;
        step(); clear_in();
        step(); step(); look();
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        step(); look();
        chk("wrap_pc2", pc_out, 32'h0);

        // Asynchronous reset mid-FLUSH
        apply_reset();
        bv = 1; bt = 1; tgt = 32'h500;
        step(); clear_in();
        look();
        chk("mid_pc", pc_out, 32'h500);
        chk("mid_flush", {31'd0, flush}, 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_fetch", {31'd0, fetch_valid}, 32'd1);
        @(posedge clk); #2 rst = 0;
        look();
        chk("arst_pc2", pc_out, 32'h0);
        chk("arst_flush2", {31'd0, flush}, 32'd0);
        step(); look();
        chk("arst_pc3", pc_out, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
